// File: rtl/mips_mc_ctrl_if.sv
// Memory handshake bundle between the multi-cycle control FSM and the
// instruction/data memories.
interface mips_mc_ctrl_if;
  // A request is held high until the matching ack. The transfer completes in
  // the cycle where req && ack. An ack with no request present is ignored.
  logic imem_req;
  logic imem_ack;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ack;

  modport master (
    output imem_req,
    output dmem_req,
    output dmem_we,
    input  imem_ack,
    input  dmem_ack
  );

  modport slave (
    input  imem_req,
    input  dmem_req,
    input  dmem_we,
    output imem_ack,
    output dmem_ack
  );
endinterface

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM: fetch, decode, exec, mem, writeback with memory timeout.
// Optional performance counters are enabled by defining MIPS_CTRL_PERF_EN.
module mips_mc_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  mips_mc_ctrl_if.master      mem,
  output logic                ir_load,
  input  logic                dec_write_reg,
  input  logic                dec_write_mem,
  input  logic                dec_jal,
  input  logic                dec_invalid,
  output logic                rf_we,
  output logic                pc_load,
  output logic                pc_sel_jump,
  output logic                instr_retired,
  output logic [2:0]          state,
  output logic                halted,
  output logic                error
`ifdef MIPS_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]    perf_retired,
  output logic [CNT_W-1:0]    perf_stall
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] wait_cnt;
  logic       wr_q, wm_q, jal_q;
  logic       timed_out;

  assign state     = state_q;
  assign timed_out = (wait_cnt == WAIT_LAST);

  // State register, wait counter and decode flags latched in DECODE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wait_cnt <= 8'd0;
      wr_q     <= 1'b0;
      wm_q     <= 1'b0;
      jal_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      // Counts consecutive ack-less cycles; any state change restarts it.
      if ((state_d == state_q) && ((state_q == S_FETCH) || (state_q == S_MEM)))
        wait_cnt <= wait_cnt + 8'd1;
      else
        wait_cnt <= 8'd0;
      if (state_q == S_DECODE) begin
        wr_q  <= dec_write_reg;
        wm_q  <= dec_write_mem;
        jal_q <= dec_jal;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH: begin
        if (mem.imem_ack)   state_d = S_DECODE;
        else if (timed_out) state_d = S_ERR;
      end
      S_DECODE: state_d = dec_invalid ? S_HALT : S_EXEC;
      S_EXEC: begin
        if (wm_q)      state_d = S_MEM;
        else if (wr_q) state_d = S_WB;
        else           state_d = run ? S_FETCH : S_IDLE;
      end
      S_MEM: begin
        // An ack on the final allowed cycle still completes the access.
        if (mem.dmem_ack)   state_d = run ? S_FETCH : S_IDLE;
        else if (timed_out) state_d = S_ERR;
      end
      S_WB:     state_d = run ? S_FETCH : S_IDLE;
      default:  state_d = state_q;
    endcase
  end

  always_comb begin
    mem.imem_req  = 1'b0;
    mem.dmem_req  = 1'b0;
    mem.dmem_we   = 1'b0;
    ir_load       = 1'b0;
    rf_we         = 1'b0;
    pc_load       = 1'b0;
    pc_sel_jump   = 1'b0;
    instr_retired = 1'b0;
    halted        = 1'b0;
    error         = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem.imem_req = 1'b1;
        ir_load      = mem.imem_ack;
      end
      S_EXEC: begin
        pc_load       = !wm_q && !wr_q;
        instr_retired = !wm_q && !wr_q;
      end
      S_MEM: begin
        mem.dmem_req  = 1'b1;
        mem.dmem_we   = 1'b1;
        pc_load       = mem.dmem_ack;
        instr_retired = mem.dmem_ack;
      end
      S_WB: begin
        rf_we         = 1'b1;
        pc_load       = 1'b1;
        pc_sel_jump   = jal_q;
        instr_retired = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      S_ERR:   error  = 1'b1;
      default: ;
    endcase
  end

`ifdef MIPS_CTRL_PERF_EN
  logic stall;
  assign stall = (mem.imem_req && !mem.imem_ack) || (mem.dmem_req && !mem.dmem_ack);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_retired <= '0;
      perf_stall   <= '0;
    end else if ((state_q != S_HALT) && (state_q != S_ERR)) begin
      if (instr_retired) perf_retired <= perf_retired + 1'b1;
      if (stall)         perf_stall   <= perf_stall + 1'b1;
    end
  end
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Bench for mips_mc_ctrl: scenario-level model expands each instruction into a
// per-cycle trace of inputs and required outputs; one process drives and checks it.
`timescale 1ns/1ps
module tb_mips_mc_ctrl;
  localparam int TO = 16;

  // Output vector bit positions
  localparam logic [9:0] O_IREQ = 10'b10_0000_0000;
  localparam logic [9:0] O_IRL  = 10'b01_0000_0000;
  localparam logic [9:0] O_DREQ = 10'b00_1000_0000;
  localparam logic [9:0] O_DWE  = 10'b00_0100_0000;
  localparam logic [9:0] O_RF   = 10'b00_0010_0000;
  localparam logic [9:0] O_PCL  = 10'b00_0001_0000;
  localparam logic [9:0] O_PCS  = 10'b00_0000_1000;
  localparam logic [9:0] O_RET  = 10'b00_0000_0100;
  localparam logic [9:0] O_HLT  = 10'b00_0000_0010;
  localparam logic [9:0] O_ERR  = 10'b00_0000_0001;

  typedef struct packed {
    logic       chk;
    logic       rst;
    logic       run;
    logic       iack;
    logic       wr;
    logic       wm;
    logic       jal;
    logic       inv;
    logic       dack;
    logic [2:0] st;
    logic [9:0] o;
  } vec_t;
  localparam int W = $bits(vec_t);

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b0;
  logic dec_write_reg = 1'b0, dec_write_mem = 1'b0, dec_jal = 1'b0, dec_invalid = 1'b0;
  logic ir_load, rf_we, pc_load, pc_sel_jump, instr_retired, halted, error;
  logic [2:0] state;
`ifdef MIPS_CTRL_PERF_EN
  logic [31:0] perf_retired, perf_stall;
  logic [31:0] m_ret = '0, m_stall = '0;
`endif

  always #5 clk = ~clk;

  mips_mc_ctrl_if bus ();

  mips_mc_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .run           (run),
    .mem           (bus),
    .ir_load       (ir_load),
    .dec_write_reg (dec_write_reg),
    .dec_write_mem (dec_write_mem),
    .dec_jal       (dec_jal),
    .dec_invalid   (dec_invalid),
    .rf_we         (rf_we),
    .pc_load       (pc_load),
    .pc_sel_jump   (pc_sel_jump),
    .instr_retired (instr_retired),
    .state         (state),
    .halted        (halted),
    .error         (error)
`ifdef MIPS_CTRL_PERF_EN
    ,
    .perf_retired  (perf_retired),
    .perf_stall    (perf_stall)
`endif
  );

  initial begin
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
  end

  // ---------------- model: instruction -> cycle trace ----------------
  task automatic push(input logic rst_v, run_v, iack_v, wr_v, wm_v, jal_v, inv_v, dack_v,
                      input logic [2:0] st_v, input logic [9:0] o_v, input logic chk_v);
    vec_t v;
    v.chk = chk_v; v.rst = rst_v; v.run = run_v; v.iack = iack_v;
    v.wr = wr_v; v.wm = wm_v; v.jal = jal_v; v.inv = inv_v; v.dack = dack_v;
    v.st = st_v; v.o = o_v;
    exp_q.push_back(v);
  endtask

  task automatic push_s(input logic [2:0] st_v, input logic [9:0] o_v,
                        input logic run_v, input logic iack_v, input logic dack_v);
    push(1'b0, run_v, iack_v, 1'b0, 1'b0, 1'b0, 1'b0, dack_v, st_v, o_v, 1'b1);
  endtask

  task automatic do_reset();
    push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 10'd0, 1'b0);
  endtask

  task automatic idle(input int n, input logic run_v);
    for (int i = 0; i < n; i++) push_s(3'd0, 10'd0, run_v, 1'b0, 1'b0);
  endtask

  // One instruction starting in FETCH: fwait/mwait ack-less cycles before each ack,
  // run_mid is the run level from EXEC to retirement.
  task automatic instr(input logic wr, wm, jal, inv, input int fwait, input int mwait,
                       input logic run_mid);
    int nf;
    nf = (fwait < TO) ? fwait : TO;
    for (int i = 0; i < nf; i++) push_s(3'd1, O_IREQ, 1'b1, 1'b0, 1'b0);
    if (fwait >= TO) begin
      for (int i = 0; i < 5; i++) push_s(3'd7, O_ERR, 1'b1, 1'b0, 1'b0);
      return;
    end
    push_s(3'd1, O_IREQ | O_IRL, 1'b1, 1'b1, 1'b0);
    push(1'b0, 1'b1, 1'b0, wr, wm, jal, inv, 1'b0, 3'd2, 10'd0, 1'b1);
    if (inv) begin
      for (int i = 0; i < 22; i++) push_s(3'd6, O_HLT, 1'b1, 1'b0, 1'b0);
      return;
    end
    push_s(3'd3, (!wm && !wr) ? (O_PCL | O_RET) : 10'd0, run_mid, 1'b0, 1'b0);
    if (wm) begin
      for (int i = 0; i < mwait; i++) push_s(3'd4, O_DREQ | O_DWE, run_mid, 1'b0, 1'b0);
      push_s(3'd4, O_DREQ | O_DWE | O_PCL | O_RET, run_mid, 1'b0, 1'b1);
    end else if (wr) begin
      push_s(3'd5, O_RF | O_PCL | (jal ? O_PCS : 10'd0) | O_RET, run_mid, 1'b0, 1'b0);
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  task automatic run_q();
    vec_t v;
    logic [12:0] act;
    while (exp_q.size() > 0) begin
      v = vec_t'(exp_q.pop_front());
      @(negedge clk);
      rst = v.rst; run = v.run;
      bus.imem_ack = v.iack; bus.dmem_ack = v.dack;
      dec_write_reg = v.wr; dec_write_mem = v.wm; dec_jal = v.jal; dec_invalid = v.inv;
      #1;
      if (v.chk) begin
        act = {state, bus.imem_req, ir_load, bus.dmem_req, bus.dmem_we, rf_we, pc_load,
               pc_sel_jump, instr_retired, halted, error};
        n_checks++;
        if (act !== {v.st, v.o}) begin
          n_fail++;
          $display("FAIL cyc%0d state/outs: got st=%0d o=%b, required st=%0d o=%b",
                   cyc, act[12:10], act[9:0], v.st, v.o);
        end
`ifdef MIPS_CTRL_PERF_EN
        check($sformatf("cyc%0d perf_retired", cyc), perf_retired, m_ret);
        check($sformatf("cyc%0d perf_stall", cyc), perf_stall, m_stall);
`endif
      end
`ifdef MIPS_CTRL_PERF_EN
      if (v.rst) begin
        m_ret = '0; m_stall = '0;
      end else begin
        m_ret   = m_ret + 32'(v.o[2]);
        m_stall = m_stall + 32'((v.o[9] && !v.iack) || (v.o[7] && !v.dack));
      end
`endif
      cyc++;
    end
  endtask

  // Sum one output bit (or match a state) over a slice of the queued trace.
  function automatic int count_bit(input int base, input int n, input logic [9:0] mask);
    vec_t t;
    int c = 0;
    for (int i = 0; i < n; i++) begin
      t = vec_t'(exp_q[base + i]);
      if ((t.o & mask) != 10'd0) c++;
    end
    return c;
  endfunction

  // ---------------- directed scenarios ----------------
  initial begin
    int base;
    vec_t t;
    logic [11:0] seq;

    do_reset();
    idle(1, 1'b1);
    // addu zero-wait: pin the trace to FETCH, DECODE, EXEC, WB
    base = exp_q.size();
    instr(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    seq = '0;
    for (int i = 0; i < 4; i++) begin
      t = vec_t'(exp_q[base + i]);
      seq = {seq[8:0], t.st};
    end
    check("model addu states", {20'd0, seq}, 32'b001_010_011_101);
    check("model addu length", exp_q.size() - base, 4);
    check("model addu pc_load pulses", count_bit(base, 4, O_PCL), 1);
    // jal
    instr(1'b1, 1'b0, 1'b1, 1'b0, 1, 0, 1'b1);
    // sw with 3 wait cycles
    base = exp_q.size();
    instr(1'b0, 1'b1, 1'b0, 1'b0, 0, 3, 1'b1);
    check("model sw dmem_req cycles", count_bit(base, exp_q.size() - base, O_DREQ), 4);
    check("model sw rf_we cycles", count_bit(base, exp_q.size() - base, O_RF), 0);
    // no-side-effect instruction retires in EXEC
    instr(1'b0, 1'b0, 1'b0, 1'b0, 2, 0, 1'b1);
    // fetch ack on the 16th cycle is accepted
    instr(1'b1, 1'b0, 1'b0, 1'b0, TO - 1, 0, 1'b1);
    // no ack by the 16th cycle: ERR
    instr(1'b1, 1'b0, 1'b0, 1'b0, TO, 0, 1'b1);
    run_q();
    check("err sticky state", {29'd0, state}, 7);
    check("err flag", {31'd0, error}, 1);

    do_reset();
    idle(1, 1'b1);
    instr(1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 1'b1);
    run_q();
    check("halt state", {29'd0, state}, 6);

    do_reset();
    idle(2, 1'b0);
    idle(1, 1'b1);
    // run drops in EXEC of a store with 2 dmem waits
    instr(1'b0, 1'b1, 1'b0, 1'b0, 0, 2, 1'b0);
    idle(4, 1'b0);
    run_q();
    check("idle after run drop", {29'd0, state}, 0);
`ifdef MIPS_CTRL_PERF_EN
    check("perf_retired after run drop", perf_retired, 1);
    check("perf_stall after run drop", perf_stall, 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
- Multi-cycle control FSM for the MIPS core.
- Sequences instruction fetch, decode, execute, memory write and register writeback around the combinational instruction decoder.
- Holds imem/dmem request/ack handshakes and issues single-cycle enables to the PC, IR and register file.
- Detects invalid opcodes (halt) and memory timeouts (error).

Parameters:
- MEM_TIMEOUT, 16, maximum cycles a memory request may wait for ack before entering ERR (legal range 2..255).
- CNT_W, 32, width of performance counters (used only with MIPS_CTRL_PERF_EN).

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  level enable; 1 = execute instructions.
- imem_req  out  1  instruction fetch request.
- imem_ack  in  1  fetch data valid this cycle.
- ir_load  out  1  load IR from imem data.
- dec_write_reg  in  1  decoder: instruction writes the register file.
- dec_write_mem  in  1  decoder: instruction writes memory (sw).
- dec_jal  in  1  decoder: jump-and-link.
- dec_invalid  in  1  decoder: ALU control is the invalid code.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write strobe.
- dmem_ack  in  1  data memory access complete.
- rf_we  out  1  register file write enable.
- pc_load  out  1  update PC.
- pc_sel_jump  out  1  PC source: 1 = jump target, 0 = PC+4.
- instr_retired  out  1  one-cycle pulse per completed instruction.
- state  out  3  current FSM state (debug).
- halted  out  1  sticky: invalid instruction seen.
- error  out  1  sticky: memory timeout.

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, ERR=7.
- Reset: state=IDLE, wait counter=0, latched decode flags=0. All outputs are 0 in the cycle after rst is sampled high. A reset mid-instruction abandons the instruction, and any in-flight memory request is dropped.
- Outputs are combinational from state, the latched flags and the acks. Nothing is asserted in IDLE.
- IDLE:
  - run=1 → FETCH.
  - run=0 → stay in IDLE.
- FETCH:
  - imem_req=1 held every cycle in FETCH.
  - imem_ack=1 → ir_load=1 in the same cycle, then → DECODE. An ack in the first FETCH cycle is legal (single-cycle fetch).
- DECODE (1 cycle):
  - Latch dec_write_reg, dec_write_mem and dec_jal.
  - dec_invalid=1 → HALT; otherwise → EXEC.
- EXEC (1 cycle; ALU operates). Next state:
  - latched write_mem=1 → MEM.
  - else latched write_reg=1 → WB.
  - else (no side effects) → pc_load=1, instr_retired=1, then → FETCH if run=1, else → IDLE.
- MEM:
  - dmem_req=1 and dmem_we=1 held.
  - dmem_ack=1 → pc_load=1 and instr_retired=1 in the same cycle, then → FETCH if run=1, else → IDLE.
- WB (1 cycle):
  - rf_we=1, pc_load=1, pc_sel_jump=latched jal, instr_retired=1.
  - Next: → FETCH if run=1, else → IDLE.
- Timeout:
  - The wait counter clears on entry to FETCH or MEM and increments each cycle without an ack.
  - If the MEM_TIMEOUT-th consecutive cycle has no ack → ERR.
  - An ack on exactly that cycle is accepted normally; the ack wins.
- HALT: halted=1; all other outputs 0. Sticky until rst.
- ERR: error=1; all other outputs 0. Sticky until rst.
- run is only sampled at IDLE and at instruction boundaries. Deasserting run mid-instruction lets the instruction complete.
- Minimum latency with zero-wait memory:
  - addu/addiu/jal: 4 cycles (FETCH, DECODE, EXEC, WB).
  - sw: 4 cycles (FETCH, DECODE, EXEC, MEM).
- pc_load is asserted exactly once per retired instruction and never in HALT or ERR.

Optional Feature:
- Macro: MIPS_CTRL_PERF_EN.
- Defined: adds output ports perf_retired[CNT_W] and perf_stall[CNT_W].
  - perf_retired increments on every instr_retired pulse.
  - perf_stall increments every cycle in which (imem_req && !imem_ack) || (dmem_req && !dmem_ack).
  - Both counters are cleared by rst, wrap modulo 2^CNT_W, and freeze in HALT and ERR.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- addu, zero-wait:
  - Stimulus: run=1; imem_ack=1 in the first FETCH cycle; decoder gives write_reg=1, write_mem=0, jal=0.
  - Required: state sequence 1,2,3,5,1. rf_we, pc_load and instr_retired each pulse once, in the WB cycle. pc_sel_jump=0.
- sw with 3 wait cycles:
  - Stimulus: write_mem=1; dmem_ack asserted on the 4th MEM cycle.
  - Required: dmem_req and dmem_we high for 4 cycles. pc_load=1 only in the ack cycle. rf_we is never asserted.
- jal:
  - Stimulus: jal=1, write_reg=1.
  - Required: WB cycle has rf_we=1, pc_sel_jump=1, pc_load=1.
- Invalid opcode:
  - Stimulus: dec_invalid=1 in DECODE.
  - Required: state=6 and halted=1 from the next cycle, held 20+ cycles with no req/enable outputs. rst=1 for one cycle returns state=0 and halted=0.
- Timeout boundary (MEM_TIMEOUT=16):
  - Stimulus A: imem_ack arrives on the 16th FETCH cycle. Required: DECODE entered normally.
  - Stimulus B: no ack by the 16th cycle. Required: state=7 and error=1.
- run drop mid-sw:
  - Stimulus: run→0 during MEM.
  - Required: the store completes with instr_retired=1, then state=IDLE and imem_req stays 0.
  - With MIPS_CTRL_PERF_EN: perf_retired=1 and perf_stall equals the number of dmem wait cycles.
